// File: rtl/memory_dumper_if.sv
// Bundles the dump control, RAM read port and output stream of memory_dumper.
interface memory_dumper_if #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8
);
    logic                     start_dump;
    logic [MEM_ADDR_SIZE-1:0] start_addr;
    logic [MEM_ADDR_SIZE-1:0] end_addr;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic                     mem_read;
    logic [WORD_SIZE-1:0]     mem_read_data;
    logic [WORD_SIZE-1:0]     out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     dump_busy;
    logic                     dump_complete;

    modport master (
        input  start_dump, start_addr, end_addr, mem_read_data, out_ready,
        output mem_addr, mem_read, out_data, out_valid, out_last, dump_busy, dump_complete
    );

    modport slave (
        output start_dump, start_addr, end_addr, mem_read_data, out_ready,
        input  mem_addr, mem_read, out_data, out_valid, out_last, dump_busy, dump_complete
    );
endinterface

// File: rtl/memory_dumper.sv
// Streams RAM[start_addr..end_addr] out one word per READ/WAIT/SEND round.
// Define DUMP_CHECKSUM_EN to append an XOR checksum word to every dump.
module memory_dumper #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8
) (
    input  logic             clock,
    input  logic             reset,
    memory_dumper_if.master  bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t                   state, next_state;
    logic [MEM_ADDR_SIZE-1:0] counter, end_q;
    logic [WORD_SIZE-1:0]     data_q;
    logic                     last_q;
    logic                     at_end, empty_range;
    logic                     mem_read, out_valid, dump_busy, dump_complete;
`ifdef DUMP_CHECKSUM_EN
    logic [WORD_SIZE-1:0]     checksum;
    logic                     csum_phase;
`endif

    assign at_end      = (counter == end_q);
    assign empty_range = (bus.start_addr > bus.end_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        out_valid     = 1'b0;
        dump_busy     = 1'b0;
        dump_complete = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_dump) begin
`ifdef DUMP_CHECKSUM_EN
                    next_state = empty_range ? SEND : READ;
`else
                    next_state = empty_range ? DONE : READ;
`endif
                end
            end
            READ: begin
                mem_read   = 1'b1;
                dump_busy  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                dump_busy  = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                dump_busy = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    // The checksum word is sent from SEND again right after the last data word.
                    if (csum_phase)  next_state = DONE;
                    else if (at_end) next_state = SEND;
                    else             next_state = READ;
`else
                    next_state = at_end ? DONE : READ;
`endif
                end
            end
            DONE: begin
                dump_complete = 1'b1;
                if (!bus.start_dump) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            end_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start_dump) begin
                    counter <= bus.start_addr;
                    end_q   <= bus.end_addr;
                    last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    checksum   <= '0;
                    data_q     <= '0;
                    csum_phase <= empty_range;
                    last_q     <= empty_range;
`endif
                end
                WAIT: begin
                    data_q <= bus.mem_read_data;
`ifdef DUMP_CHECKSUM_EN
                    checksum <= checksum ^ bus.mem_read_data;
`else
                    last_q   <= at_end;
`endif
                end
                SEND: if (bus.out_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    if (!csum_phase && at_end) begin
                        data_q     <= checksum;
                        last_q     <= 1'b1;
                        csum_phase <= 1'b1;
                    end else if (!csum_phase) begin
                        counter <= counter + MEM_ADDR_SIZE'(1);
                    end
`else
                    // Equality test precedes the increment, so end_addr at the top never wraps.
                    if (!at_end) counter <= counter + MEM_ADDR_SIZE'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr      = counter;
    assign bus.mem_read      = mem_read;
    assign bus.out_data      = data_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = last_q & (state == SEND);
    assign bus.dump_busy     = dump_busy;
    assign bus.dump_complete = dump_complete;
endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: RAM model, stream monitor and a reference dump model.
module tb_memory_dumper;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [15:0] ram [256];
    logic [15:0] got_data[$];
    bit          got_last[$];
    int          got_cyc[$];
    int          rd_addr[$];
    logic [15:0] exp_data[$];
    bit          exp_last[$];

    memory_dumper_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) bus();
    memory_dumper #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (bus.mem_read) bus.mem_read_data <= ram[bus.mem_addr];

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
            if (bus.mem_read) rd_addr.push_back(int'(bus.mem_addr));
        end
    end

    // Reference: every address s..e once, in order; optional XOR word; last flag on the final word only.
    function automatic void build_exp(input int s, input int e);
        logic [15:0] x;
        x = 16'h0;
        exp_data.delete();
        exp_last.delete();
        for (int a = s; a <= e; a++) begin
            exp_data.push_back(ram[a]);
            exp_last.push_back(1'b0);
            x ^= ram[a];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_data.push_back(x);
        exp_last.push_back(1'b0);
`endif
        if (exp_data.size() > 0) exp_last[exp_data.size()-1] = 1'b1;
    endfunction

    function automatic void clear_logs();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        rd_addr.delete();
    endfunction

    task automatic run_dump(input int s, input int e, input int mode, input bit keep_start, output bit ok);
        clear_logs();
        build_exp(s, e);
        ok = 1'b0;
        bus.start_addr = 8'(s);
        bus.end_addr   = 8'(e);
        bus.start_dump = 1'b1;
        bus.out_ready  = (mode == 0);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.dump_complete) begin ok = 1'b1; break; end
        end
        if (!keep_start) begin
            bus.start_dump = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++; if ({bus.mem_read, bus.out_valid, bus.out_last, bus.dump_busy, bus.dump_complete} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl got=%b want=00000", {bus.mem_read, bus.out_valid, bus.out_last, bus.dump_busy, bus.dump_complete});
        end
        tests++; if (bus.out_data !== 16'h0 || bus.mem_addr !== 8'h0) begin
            fails++; $display("FAIL reset_data out_data=%h mem_addr=%h want 0/0", bus.out_data, bus.mem_addr);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        bit ok;
        bit bad;
        ram[16] = 16'h1111; ram[17] = 16'h2222; ram[18] = 16'h4444;
        run_dump(16, 18, 0, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got=0 want=1"); end
        tests++; if (got_data.size() != exp_data.size()) begin
            fails++; $display("FAIL basic_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        foreach (exp_data[i]) begin
            tests++; if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                fails++; $display("FAIL basic_word%0d got=%h/%0b want=%h/%0b", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, (i < got_last.size()) ? got_last[i] : 1'b0, exp_data[i], exp_last[i]);
            end
        end
`ifdef DUMP_CHECKSUM_EN
        tests++; if (exp_data.size() != 4 || exp_data[3] !== 16'h7777) begin
            fails++; $display("FAIL basic_csum_model got=%0d words want=4 ending 7777", exp_data.size());
        end
`endif
        if (got_cyc.size() >= 3) begin
            tests++; if (got_cyc[1] - got_cyc[0] != 3 || got_cyc[2] - got_cyc[1] != 3) begin
                fails++; $display("FAIL basic_rate got=%0d,%0d want=3,3", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
            end
        end
        bad = (rd_addr.size() != 3);
        foreach (rd_addr[i]) if (rd_addr[i] != 16 + i) bad = 1'b1;
        tests++; if (bad) begin fails++; $display("FAIL basic_reads got=%0d reads want=3 at 0x10..0x12", rd_addr.size()); end
        tests++; if (bus.dump_complete !== 1'b0 || bus.dump_busy !== 1'b0) begin
            fails++; $display("FAIL basic_idle complete=%b busy=%b want 0/0", bus.dump_complete, bus.dump_busy);
        end
    endtask

    task automatic test_stall();
        logic [15:0] d;
        bit l;
        bit ok;
        clear_logs();
        build_exp(16, 18);
        bus.start_addr = 8'h10; bus.end_addr = 8'h12;
        bus.out_ready = 1'b0; bus.start_dump = 1'b1;
        foreach (exp_data[w]) begin
            for (int c = 0; c < 50 && !bus.out_valid; c++) begin @(posedge clock); #1; end
            tests++; if (!bus.out_valid) begin fails++; $display("FAIL stall_valid%0d got=0 want=1", w); break; end
            d = bus.out_data; l = bus.out_last;
            for (int k = 0; k < 5; k++) begin
                @(posedge clock); #1;
                tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== l || bus.mem_read !== 1'b0) begin
                    fails++; $display("FAIL stall_hold%0d got=%b/%h/%b/%b want=1/%h/%b/0", w, bus.out_valid, bus.out_data, bus.out_last, bus.mem_read, d, l);
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clock); #1;
            bus.out_ready = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.dump_complete) begin ok = 1'b1; break; end
            @(posedge clock); #1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL stall_done got=0 want=1"); end
        tests++; if (got_data != exp_data || got_last != exp_last) begin
            fails++; $display("FAIL stall_seq got=%0d words want=%0d words", got_data.size(), exp_data.size());
        end
        tests++; if (rd_addr.size() != 3) begin fails++; $display("FAIL stall_reads got=%0d want=3", rd_addr.size()); end
        bus.start_dump = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_top_addr();
        bit ok;
        ram[255] = 16'hBEEF;
        run_dump(255, 255, 0, 1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL top_timeout got=0 want=1"); end
        tests++; if (rd_addr.size() != 1 || rd_addr[0] != 255) begin
            fails++; $display("FAIL top_reads got=%0d reads want=1 at 0xff", rd_addr.size());
        end
        tests++; if (got_data.size() < 1 || got_data[0] !== 16'hBEEF || got_data != exp_data || got_last != exp_last) begin
            fails++; $display("FAIL top_words got=%0d words want=%0d first BEEF", got_data.size(), exp_data.size());
        end
        tests++; if (bus.mem_addr !== 8'hFF) begin fails++; $display("FAIL top_nowrap got=%h want=ff", bus.mem_addr); end
        bus.start_dump = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_empty();
        bit ok;
        run_dump(32, 31, 0, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL empty_done got=0 want=1"); end
        tests++; if (rd_addr.size() != 0) begin fails++; $display("FAIL empty_reads got=%0d want=0", rd_addr.size()); end
        tests++; if (got_data != exp_data || got_last != exp_last) begin
            fails++; $display("FAIL empty_words got=%0d want=%0d", got_data.size(), exp_data.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        for (int a = 64; a < 68; a++) ram[a] = 16'($urandom);
        clear_logs();
        bus.start_addr = 8'h40; bus.end_addr = 8'h43;
        bus.out_ready = 1'b0; bus.start_dump = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(posedge clock); #1;
            if (bus.out_valid) begin
                seen++;
                if (seen == 1) begin
                    bus.out_ready = 1'b1;
                    @(posedge clock); #1;
                    bus.out_ready = 1'b0;
                end
            end
        end
        tests++; if (seen != 2) begin fails++; $display("FAIL midrst_reach got=%0d want=2", seen); end
        #3 reset = 1'b1;
        #1;
        tests++; if ({bus.mem_read, bus.out_valid, bus.out_last, bus.dump_busy, bus.dump_complete} !== 5'b0 ||
                     bus.out_data !== 16'h0 || bus.mem_addr !== 8'h0) begin
            fails++; $display("FAIL midrst_outputs got=%b data=%h addr=%h want 0", {bus.mem_read, bus.out_valid, bus.out_last, bus.dump_busy, bus.dump_complete}, bus.out_data, bus.mem_addr);
        end
        bus.start_dump = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_dump(64, 67, 0, 0, ok);
        tests++; if (!ok || got_data != exp_data || got_last != exp_last || rd_addr.size() != 4) begin
            fails++; $display("FAIL midrst_rerun got=%0d words/%0d reads want=%0d/4", got_data.size(), rd_addr.size(), exp_data.size());
        end
    endtask

    task automatic test_hold_start();
        bit ok;
        int n;
        run_dump(48, 49, 0, 1, ok);
        n = rd_addr.size();
        tests++; if (!ok || n != 2) begin fails++; $display("FAIL hold_first got=%0d reads want=2", n); end
        repeat (8) @(posedge clock);
        #1;
        tests++; if (bus.dump_complete !== 1'b1 || rd_addr.size() != n || got_data.size() != exp_data.size()) begin
            fails++; $display("FAIL hold_stay complete=%b reads=%0d want 1/%0d", bus.dump_complete, rd_addr.size(), n);
        end
        bus.start_dump = 1'b0;
        @(posedge clock); #1;
        tests++; if (bus.dump_complete !== 1'b0 || bus.dump_busy !== 1'b0) begin
            fails++; $display("FAIL hold_release complete=%b busy=%b want 0/0", bus.dump_complete, bus.dump_busy);
        end
    endtask

    task automatic test_random();
        bit ok;
        int s, e;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(1, 250);
            e = s + $urandom_range(0, 6) - 1;
            if (e > 255) e = 255;
            run_dump(s, e, 1, 0, ok);
            tests++; if (!ok || got_data != exp_data || got_last != exp_last || rd_addr.size() != ((e >= s) ? e - s + 1 : 0)) begin
                fails++; $display("FAIL random%0d s=%0d e=%0d got=%0d words/%0d reads want=%0d words", it, s, e, got_data.size(), rd_addr.size(), exp_data.size());
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 16'($urandom);
        bus.start_dump = 1'b0;
        bus.start_addr = 8'h0;
        bus.end_addr   = 8'h0;
        bus.out_ready  = 1'b0;
        bus.mem_read_data = 16'h0;
        test_reset();
        test_basic();
        test_stall();
        test_top_addr();
        test_empty();
        test_reset_mid();
        test_hold_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
